parity_frame_tx_ctrl: RTL and testbench
=======================================

Name: parity_frame_tx_ctrl

Overview:
Sequencer around the even-parity datapath. It accepts parallel data words over a valid/ready handshake and computes even parity (XOR-reduce of the word). It then shifts out a serial frame: start bit, data LSB-first, parity bit, stop bit. It sits between a word producer and a single-wire serial link. Its bit-level timing is set by a programmable clocks-per-bit divider.

Parameters:
DATA_WIDTH, 4, data word width in bits; legal values ≥1.
CLKS_PER_BIT, 1, clock cycles each serial bit is held on tx_out; legal values ≥1.

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_data  input  DATA_WIDTH  word to transmit
in_valid  input  1  producer has a word on in_data
in_ready  output  1  controller can accept a word this cycle
tx_out  output  1  serial line; idles high
parity_out  output  1  even-parity bit of the word currently being framed
busy  output  1  frame in progress (any state other than IDLE)
frame_done  output  1  one-cycle pulse in the final cycle of STOP

Behaviour:
- Reset (rst=1 at clock edge) puts the block in the following state on the next cycle: state=IDLE, tx_out=1, parity_out=0, busy=0, frame_done=0, in_ready=1. Bit and divider counters are cleared. Reset overrides all other inputs.
- Reset mid-frame aborts the frame immediately. tx_out returns to 1 on the next edge, no frame_done pulse is generated, and the latched word is discarded.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- in_ready is 1 only in IDLE, and is combinational from state.
- Accept condition: in_valid & in_ready at a rising edge. On accept:
  - in_data is latched into a shift register.
  - parity_out <= ^in_data, so the total count of ones in data plus parity is even.
  - The state moves to START.
  - in_data changes after accept have no effect.
- in_valid while busy is ignored. The word is not consumed, and the producer must hold it until in_ready.
- tx_out is registered. Values by state:
  - START: 0.
  - DATA: shift-register bit 0 (LSB first).
  - PARITY: parity_out.
  - STOP: 1.
  - IDLE: 1.
- Bit timing:
  - Each state from START through STOP holds tx_out for exactly CLKS_PER_BIT cycles.
  - The divider counter runs 0..CLKS_PER_BIT-1. Wrap-around advances the bit or state.
  - DATA lasts DATA_WIDTH bit periods. The shift register shifts right once per bit period. The bit counter runs 0..DATA_WIDTH-1; on its terminal count the state moves to PARITY.
- Frame length is (DATA_WIDTH+3)*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
- frame_done is high during the last STOP cycle. The next cycle is IDLE.
- Minimum spacing between consecutive accepts is one IDLE cycle. Back-to-back frames are therefore separated by exactly one idle-high cycle.
- busy=1 from the cycle after accept through the last STOP cycle inclusive.
- parity_out holds its value until the next accept or reset.
- The CLKS_PER_BIT=1 edge case must work: no divider wait, one cycle per bit.
- DATA_WIDTH=1: a single DATA bit period.

Optional Feature:
Macro PARITY_ERR_INJECT_EN.
- When defined, the block adds input port inject_err (1 bit), sampled at accept.
  - If inject_err=1 at accept, the transmitted parity bit is inverted (odd parity on the line) for that frame only.
  - parity_out still reports the true even parity.
  - inject_err at any other time has no effect.
- When not defined, the port does not exist and parity is always even.

Test Plan:
- Reset, no traffic: hold rst=1 for 2 cycles, then release and run 5 cycles. Required: tx_out=1, in_ready=1, busy=0, parity_out=0, frame_done=0 throughout.
- CLKS_PER_BIT=1, send 4'b1010: accept at cycle 0.
  - Required tx_out over cycles 1-7: 0,0,1,0,1,0,1.
  - parity_out=0.
  - busy=1 for cycles 1-7, with frame_done=1 at cycle 7 only.
  - in_ready=1 again at cycle 8.
- CLKS_PER_BIT=1, send 4'b0111.
  - Required tx_out sequence: 0,1,1,1,0,1,1.
  - parity_out=1.
  - The count of ones across data+parity is 4.
- CLKS_PER_BIT=3, send 4'b1111: every bit is held 3 cycles, with 21 busy cycles. Required: parity bit=0, frame_done exactly at busy cycle 21.
- Back-to-back and hold: in_valid is held high with 4'b0000 followed by 4'b0101. Required:
  - The second word is accepted exactly one cycle after the first frame_done.
  - The word 4'b0101 presented while busy is not consumed early.
  - Both parity bits are 0.
- Reset mid-frame: assert rst during the DATA state of 4'b1010. Required:
  - tx_out=1 and busy=0 on the next cycle.
  - No frame_done pulse.
  - A new word is accepted normally afterwards.
  - With PARITY_ERR_INJECT_EN defined and inject_err=1 on the following 4'b1010 frame, the line parity bit is 1 while parity_out=0.

Source files
------------

// File: rtl/parity_frame_tx_ctrl_if.sv
// Word handshake between a producer (master) and parity_frame_tx_ctrl (slave).
// valid/ready: a word moves on any rising edge where in_valid and in_ready are
// both high; the master holds in_data/in_valid stable until that edge.
interface parity_frame_tx_ctrl_if #(
  parameter int DATA_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/parity_frame_tx_ctrl.sv
// Serial frame transmitter: start bit, data LSB-first, even parity, stop bit.
// Each bit is held for CLKS_PER_BIT cycles.
// Optional macro PARITY_ERR_INJECT_EN adds inject_err, which (when sampled
// high at accept) inverts the parity bit on the line for that frame only.
module parity_frame_tx_ctrl #(
  parameter int DATA_WIDTH   = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  parity_frame_tx_ctrl_if.slave  bus,
`ifdef PARITY_ERR_INJECT_EN
  input  logic                   inject_err,
`endif
  output logic                   tx_out,
  output logic                   parity_out,
  output logic                   busy,
  output logic                   frame_done,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q;
  logic [BIT_W-1:0]      bit_q;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  line_par_q;
  logic                  accept;
  logic                  tick;
  logic                  inj;

`ifdef PARITY_ERR_INJECT_EN
  assign inj = inject_err;
`else
  assign inj = 1'b0;
`endif

  // Only IDLE accepts, so in_ready is a pure decode of the state.
  assign accept = bus.in_valid && (state_q == S_IDLE);
  // Last cycle of the current bit period.
  assign tick   = (div_q == DIV_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: advance one state per bit period; DATA spans DATA_WIDTH periods.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_START;
      S_START:  if (tick) state_d = S_DATA;
      S_DATA:   if (tick && (bit_q == BIT_LAST)) state_d = S_PARITY;
      S_PARITY: if (tick) state_d = S_STOP;
      S_STOP:   if (tick) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    bus.in_ready = (state_q == S_IDLE);
    busy         = (state_q != S_IDLE);
    frame_done   = (state_q == S_STOP) && tick;
    state_dbg    = state_q;
  end

  // Divider runs 0..CLKS_PER_BIT-1 in every non-idle state; bit counter only in DATA.
  always_ff @(posedge clk) begin
    if (rst || (state_q == S_IDLE) || tick) div_q <= '0;
    else                                    div_q <= div_q + 1'b1;
  end

  // Bit counter for the data phase.
  always_ff @(posedge clk) begin
    if (rst || (state_q != S_DATA))  bit_q <= '0;
    else if (tick)                   bit_q <= (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
  end

  // Shift register next value: load on accept, shift right at each data bit boundary.
  always_comb begin
    shreg_d = shreg_q;
    if (accept)                           shreg_d = bus.in_data;
    else if ((state_q == S_DATA) && tick) shreg_d = shreg_q >> 1;
  end

  // Datapath registers: shift register and parity captured at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q    <= '0;
      parity_out <= 1'b0;
      line_par_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      if (accept) begin
        parity_out <= ^bus.in_data;
        line_par_q <= (^bus.in_data) ^ inj;
      end
    end
  end

  // Registered line driver: value for the state being entered on this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_out <= 1'b1;
    end else begin
      case (state_d)
        S_START:  tx_out <= 1'b0;
        S_DATA:   tx_out <= shreg_d[0];
        S_PARITY: tx_out <= line_par_q;
        default:  tx_out <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_tx_ctrl.sv
// Directed bench for parity_frame_tx_ctrl: one instance at CLKS_PER_BIT=1 and
// one at CLKS_PER_BIT=3 share clock and reset.
module tb_parity_frame_tx_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  // Clock.
  always #5 clk = ~clk;

  parity_frame_tx_ctrl_if #(.DATA_WIDTH(4)) if1 ();
  parity_frame_tx_ctrl_if #(.DATA_WIDTH(4)) if3 ();

  logic       tx1, par1, busy1, fd1;
  logic       tx3, par3, busy3, fd3;
  logic [2:0] st1, st3;
  logic       inj1 = 1'b0;
  logic       inj3 = 1'b0;

  parity_frame_tx_ctrl #(.DATA_WIDTH(4), .CLKS_PER_BIT(1)) d1 (
    .clk(clk), .rst(rst), .bus(if1.slave),
`ifdef PARITY_ERR_INJECT_EN
    .inject_err(inj1),
`endif
    .tx_out(tx1), .parity_out(par1), .busy(busy1), .frame_done(fd1), .state_dbg(st1)
  );

  parity_frame_tx_ctrl #(.DATA_WIDTH(4), .CLKS_PER_BIT(3)) d3 (
    .clk(clk), .rst(rst), .bus(if3.slave),
`ifdef PARITY_ERR_INJECT_EN
    .inject_err(inj3),
`endif
    .tx_out(tx3), .parity_out(par3), .busy(busy3), .frame_done(fd3), .state_dbg(st3)
  );

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit use3, input logic v, input logic [3:0] d);
    if (use3) begin
      if3.in_valid = v;
      if3.in_data  = d;
    end else begin
      if1.in_valid = v;
      if1.in_data  = d;
    end
  endtask

  // Send one word and check every cycle of its frame plus the idle cycle after.
  task automatic run_frame(input bit use3, input logic [3:0] data, input logic exp_par,
                           input logic exp_line_par, input string tag);
    int         cpb;
    int         total;
    int         b;
    logic [6:0] fr;
    cpb   = use3 ? 3 : 1;
    total = 7 * cpb;
    fr    = {1'b1, exp_line_par, data, 1'b0};
    chk({tag, "_ready_pre"}, use3 ? if3.in_ready : if1.in_ready, 1'b1);
    drive(use3, 1'b1, data);
    step();
    // Scramble the input after accept; the frame must not change.
    drive(use3, 1'b0, 4'($urandom_range(0, 15)));
    chk({tag, "_parity_out"}, use3 ? par3 : par1, exp_par);
    for (int c = 1; c <= total; c++) begin
      b = (c - 1) / cpb;
      chk($sformatf("%s_tx_c%0d", tag, c), use3 ? tx3 : tx1, fr[b]);
      chk($sformatf("%s_busy_c%0d", tag, c), use3 ? busy3 : busy1, 1'b1);
      chk($sformatf("%s_done_c%0d", tag, c), use3 ? fd3 : fd1, (c == total));
      chk($sformatf("%s_ready_c%0d", tag, c), use3 ? if3.in_ready : if1.in_ready, 1'b0);
      step();
    end
    chk({tag, "_ready_post"}, use3 ? if3.in_ready : if1.in_ready, 1'b1);
    chk({tag, "_busy_post"}, use3 ? busy3 : busy1, 1'b0);
    chk({tag, "_tx_post"}, use3 ? tx3 : tx1, 1'b1);
    chk({tag, "_par_hold"}, use3 ? par3 : par1, exp_par);
  endtask

  initial begin
    logic [6:0] fr;
    drive(1'b0, 1'b0, 4'h0);
    drive(1'b1, 1'b0, 4'h0);

    // Reset held two cycles, then five idle cycles on both instances.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rst_tx1_%0d", i), tx1, 1'b1);
      chk($sformatf("rst_rdy1_%0d", i), if1.in_ready, 1'b1);
      chk($sformatf("rst_busy1_%0d", i), busy1, 1'b0);
      chk($sformatf("rst_par1_%0d", i), par1, 1'b0);
      chk($sformatf("rst_fd1_%0d", i), fd1, 1'b0);
      chk($sformatf("rst_st1_%0d", i), st1, 3'd0);
      chk($sformatf("rst_tx3_%0d", i), tx3, 1'b1);
      chk($sformatf("rst_busy3_%0d", i), busy3, 1'b0);
      chk($sformatf("rst_rdy3_%0d", i), if3.in_ready, 1'b1);
      step();
    end

    // CLKS_PER_BIT=1 frames: line 0,0,1,0,1,0,1 and 0,1,1,1,0,1,1.
    run_frame(1'b0, 4'b1010, 1'b0, 1'b0, "f1010");
    step();
    run_frame(1'b0, 4'b0111, 1'b1, 1'b1, "f0111");
    chk("ones_0111", 32'($countones({4'b0111, par1})), 32'd4);
    step();

    // CLKS_PER_BIT=3: 21 busy cycles, parity bit 0.
    run_frame(1'b1, 4'b1111, 1'b0, 1'b0, "f1111_x3");
    step();

    // Back-to-back with in_valid held: 0000 then 0101 waiting during the frame.
    drive(1'b0, 1'b1, 4'b0000);
    step();
    drive(1'b0, 1'b1, 4'b0101);
    fr = 7'b1000000;
    chk("b2b_par_a", par1, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("b2b_a_tx_c%0d", c), tx1, fr[c-1]);
      chk($sformatf("b2b_a_rdy_c%0d", c), if1.in_ready, 1'b0);
      chk($sformatf("b2b_a_done_c%0d", c), fd1, (c == 7));
      step();
    end
    chk("b2b_gap_rdy", if1.in_ready, 1'b1);
    chk("b2b_gap_tx", tx1, 1'b1);
    chk("b2b_gap_busy", busy1, 1'b0);
    step();
    drive(1'b0, 1'b0, 4'b1111);
    fr = 7'b1001010;
    chk("b2b_par_b", par1, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("b2b_b_tx_c%0d", c), tx1, fr[c-1]);
      chk($sformatf("b2b_b_busy_c%0d", c), busy1, 1'b1);
      step();
    end
    chk("b2b_end_rdy", if1.in_ready, 1'b1);
    step();

    // Reset during DATA of 1010 aborts the frame.
    drive(1'b0, 1'b1, 4'b1010);
    step();
    drive(1'b0, 1'b0, 4'b0000);
    step();
    step();
    chk("abort_in_data", st1, 3'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_tx", tx1, 1'b1);
    chk("abort_busy", busy1, 1'b0);
    chk("abort_fd", fd1, 1'b0);
    chk("abort_par", par1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("abort_nofd_%0d", i), fd1, 1'b0);
      chk($sformatf("abort_idle_tx_%0d", i), tx1, 1'b1);
      step();
    end

    // Fresh 1010 after the abort; with injection the line parity is flipped.
`ifdef PARITY_ERR_INJECT_EN
    inj1 = 1'b1;
    drive(1'b0, 1'b1, 4'b1010);
    step();
    inj1 = 1'b0;
    drive(1'b0, 1'b0, 4'b0000);
    fr = 7'b1101010;
    chk("inj_par_out", par1, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("inj_tx_c%0d", c), tx1, fr[c-1]);
      chk($sformatf("inj_done_c%0d", c), fd1, (c == 7));
      step();
    end
    step();
    run_frame(1'b0, 4'b1010, 1'b0, 1'b0, "post_inj");
`else
    run_frame(1'b0, 4'b1010, 1'b0, 1'b0, "post_abort");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
